block_packer: RTL

BLOCK_PACKER -- requirements
Module: block_packer

---
 rtl/block_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/block_packer.sv
// Packs a stream of bytes from I2C or SRAM into BLOCK_BYTES-wide blocks, first byte in the MSBs.
// Define PKCS_PAD_EN to pad partial blocks PKCS#7-style; otherwise flushed partial blocks are zero-padded.
module block_packer #(
  parameter int BLOCK_BYTES = 8,
  parameter int CNT_W       = 5
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     src_sel,
  input  logic [7:0]               i2c_byte,
  input  logic [7:0]               sram_byte,
  input  logic                     byte_valid,
  input  logic                     flush,
  input  logic                     blk_ready,
  output logic                     byte_ready,
  output logic                     blk_valid,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic [CNT_W-1:0]         byte_count,
  output logic                     overflow_err
);

  // state | meaning
  // FILL  | accepting bytes from the selected source
  // PAD   | writing pad bytes until the block is full
  // HOLD  | block complete, waiting for the downstream handshake
  typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

  localparam int DW = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx, cnt_inc;
  logic [DW-1:0]    data_nx;
  logic             ovf_nx;
  logic [7:0]       in_byte, pad_byte;
`ifdef PKCS_PAD_EN
  logic [7:0]       pad_val, pad_nx;
  logic             pend, pend_nx;
`endif

  function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] d,
                                             input logic [CNT_W-1:0] idx,
                                             input logic [7:0] b);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < BLOCK_BYTES; i++)
      if (idx == CNT_W'(i)) r[DW-8-8*i +: 8] = b;
    return r;
  endfunction

  assign byte_ready = (state == FILL);
  assign blk_valid  = (state == HOLD);

  always_comb begin
    state_nx = state;
    cnt_nx   = byte_count;
    data_nx  = blk_data;
    ovf_nx   = overflow_err | (byte_valid & (state != FILL));
    in_byte  = src_sel ? sram_byte : i2c_byte;
    cnt_inc  = byte_count + 1'b1;
`ifdef PKCS_PAD_EN
    pad_nx   = pad_val;
    pend_nx  = pend;
    pad_byte = pad_val;
`else
    pad_byte = 8'h00;
`endif
    case (state)
      FILL: begin
        if (byte_valid) begin
          data_nx = put_byte(blk_data, byte_count, in_byte);
          cnt_nx  = cnt_inc;
        end
        // a same-cycle byte is accepted before the flush is considered
        if (cnt_nx == FULL_CNT) begin
          state_nx = HOLD;
`ifdef PKCS_PAD_EN
          if (flush) pend_nx = 1'b1;
`endif
        end else if (flush) begin
`ifdef PKCS_PAD_EN
          state_nx = PAD;
          pad_nx   = 8'(BLOCK_BYTES) - 8'(cnt_nx);
`else
          if (cnt_nx != '0) state_nx = PAD;
`endif
        end
      end
      PAD: begin
        data_nx = put_byte(blk_data, byte_count, pad_byte);
        cnt_nx  = cnt_inc;
        if (cnt_inc == FULL_CNT) state_nx = HOLD;
      end
      HOLD: begin
        if (blk_ready) begin
          cnt_nx   = '0;
          data_nx  = '0;
          state_nx = FILL;
`ifdef PKCS_PAD_EN
          // flush landed on a block boundary: emit a whole pad block next
          if (pend) begin
            state_nx = PAD;
            pad_nx   = 8'(BLOCK_BYTES);
            pend_nx  = 1'b0;
          end
`endif
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= FILL;
      byte_count   <= '0;
      blk_data     <= '0;
      overflow_err <= 1'b0;
`ifdef PKCS_PAD_EN
      pad_val      <= 8'h00;
      pend         <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      byte_count   <= cnt_nx;
      blk_data     <= data_nx;
      overflow_err <= ovf_nx;
`ifdef PKCS_PAD_EN
      pad_val      <= pad_nx;
      pend         <= pend_nx;
`endif
    end
  end

endmodule
